// File: rtl/uart_tx_byte_fifo.sv
// uart_tx_byte_fifo
// Elastic byte buffer placed in front of uart_tx. The upstream side looks like
// the uart_tx interface (start/data/busy) so a producer can burst characters;
// the downstream side launches queued bytes into uart_tx one at a time using
// the tx_start pulse / tx_busy handshake.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   in_data   - byte from producer, sampled when in_start=1
//   in_start  - one-cycle push strobe
//   in_busy   - FIFO full, producer must not push
//   flush     - synchronous clear of queued contents (wins over push)
//   out_data  - byte to uart_tx.tx_data, stable from launch to next launch
//   out_start - one-cycle pulse to uart_tx.tx_start
//   out_busy  - uart_tx.tx_busy
//   count     - occupancy 0..DEPTH
//   empty     - count == 0
//   overflow  - sticky, a push arrived while full
module uart_tx_byte_fifo #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_start,
  output logic              in_busy,
  input  logic              flush,
  output logic [7:0]        out_data,
  output logic              out_start,
  input  logic              out_busy,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              overflow
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W - 1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_ACK    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic              in_busy_r;
  logic              empty_r;
  logic              overflow_r;
  logic              out_start_r;
  logic [7:0]        out_data_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [TMO_W-1:0]  tmo_nxt_s;
  logic [TMO_W-1:0]  tmo_inc_s;
  state_t            state_r;
  state_t            state_nxt_s;
  logic              full_s;
  logic              push_s;
  logic              launch_s;

  // Push/pop qualification and next occupancy.
  // Fullness uses the pre-edge count, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle. Launch is held off during a
  // flush so nothing leaves a queue that is being cleared.
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    push_s      = in_start && !flush && !full_s;
    launch_s    = (state_r == ST_IDLE) && (count_r != CNT_ZERO) && !out_busy && !flush;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      case ({push_s, launch_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Drain FSM next-state and ack-timeout counter.
  always_comb begin
    state_nxt_s = state_r;
    tmo_nxt_s   = tmo_r;
    tmo_inc_s   = tmo_r + TMO_ONE;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_nxt_s = ST_LAUNCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        tmo_nxt_s   = TMO_ZERO;
        state_nxt_s = ST_ACK;
      end
      ST_ACK: begin
        if (out_busy) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          // uart_tx never acknowledged: treat the byte as sent after the timeout
          tmo_nxt_s = tmo_inc_s;
          if (tmo_inc_s == TMO_MAX) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ACK;
          end
        end
      end
      ST_DRAIN: begin
        if (!out_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Byte storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, occupancy, status flags, FSM and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      in_busy_r   <= 1'b0;
      empty_r     <= 1'b1;
      overflow_r  <= 1'b0;
      out_start_r <= 1'b0;
      out_data_r  <= 8'h00;
      tmo_r       <= TMO_ZERO;
      state_r     <= ST_IDLE;
    end else begin
      if (flush) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (launch_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      if (flush) begin
        overflow_r <= 1'b0;
      end else if (in_start && full_s) begin
        overflow_r <= 1'b1;
      end
      if (launch_s) begin
        out_data_r <= mem_r[rd_ptr_r];
      end
      // Status flags derive from the same next count so they always agree
      count_r     <= count_nxt_s;
      in_busy_r   <= (count_nxt_s == FULL_CNT);
      empty_r     <= (count_nxt_s == CNT_ZERO);
      out_start_r <= launch_s;
      tmo_r       <= tmo_nxt_s;
      state_r     <= state_nxt_s;
    end
  end

  assign in_busy   = in_busy_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign out_start = out_start_r;
  assign out_data  = out_data_r;

endmodule
